// File: rtl/id_stage.sv
// RV32 instruction-decode stage: register file with optional WB bypass, immediate
// generation, upper/link result, load-use stall detection and the ID/EX register.
module id_stage #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter bit BYPASS    = 1'b1,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_is_load,
  input  logic [4:0]      ex_rd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_aux,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic            out_illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [5:0] NREGS_W = 6'(NREGS);

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] funct3;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [6:0] funct7;

  assign opcode = in_inst[6:0];
  assign rd     = in_inst[11:7];
  assign funct3 = in_inst[14:12];
  assign rs1    = in_inst[19:15];
  assign rs2    = in_inst[24:20];
  assign funct7 = in_inst[31:25];

  // Register file; x0 is not stored, so index 0 always reads zero.
  logic [XLEN-1:0] regs [1:NREGS-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 1; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_we) begin
      for (int i = 1; i < NREGS; i++) begin
        if (wb_rd == 5'(i)) regs[i] <= wb_data;
      end
    end
  end

  logic            rs1_ok;
  logic            rs2_ok;
  logic            rd_ok;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  assign rs1_ok = {1'b0, rs1} < NREGS_W;
  assign rs2_ok = {1'b0, rs2} < NREGS_W;
  assign rd_ok  = {1'b0, rd} < NREGS_W;

  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (rs1 == 5'(i)) rs1_val = regs[i];
      if (rs2 == 5'(i)) rs2_val = regs[i];
    end
    // Same-cycle WB write wins over the stored value; x0 and out-of-range stay zero.
    if (BYPASS && wb_we && wb_rd == rs1 && rs1 != 5'd0 && rs1_ok) rs1_val = wb_data;
    if (BYPASS && wb_we && wb_rd == rs2 && rs2 != 5'd0 && rs2_ok) rs2_val = wb_data;
  end

  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] aux;
  logic            known;
  logic            rs1_used;
  logic            rs2_used;
  logic            rd_used;

  always_comb begin
    imm      = '0;
    aux      = '0;
    known    = 1'b1;
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    rd_used  = 1'b1;
    case (opcode)
      OP_IMM, OP_LOAD: imm = {{20{in_inst[31]}}, in_inst[31:20]};
      OP_JALR: begin
        imm = {{20{in_inst[31]}}, in_inst[31:20]};
        aux = in_pc + XLEN'(4);
      end
      OP_STORE: begin
        imm      = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        rs2_used = 1'b1;
        rd_used  = 1'b0;
      end
      OP_BRANCH: begin
        imm      = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
        rs2_used = 1'b1;
        rd_used  = 1'b0;
      end
      OP_LUI: begin
        imm      = {in_inst[31:12], 12'b0};
        aux      = {in_inst[31:12], 12'b0};
        rs1_used = 1'b0;
      end
      OP_AUIPC: begin
        imm      = {in_inst[31:12], 12'b0};
        aux      = in_pc + {in_inst[31:12], 12'b0};
        rs1_used = 1'b0;
      end
      OP_JAL: begin
        imm      = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
        aux      = in_pc + XLEN'(4);
        rs1_used = 1'b0;
      end
      OP_OP:             rs2_used = 1'b1;
      OP_FENCE, OP_SYSTEM: known = 1'b1;
      default:           known = 1'b0;
    endcase
  end

  logic illegal;
  assign illegal = !known || (rs1_used && !rs1_ok) || (rs2_used && !rs2_ok) || (rd_used && !rd_ok);

  logic hazard;
  assign hazard = HAZARD_EN && in_valid && ex_is_load && ex_rd != 5'd0 &&
                  ((rs1_used && ex_rd == rs1) || (rs2_used && ex_rd == rs2));

  // Handshake: the ID/EX register advances when it is empty or EX takes it
  // (adv). An IF/ID instruction is taken only on an advancing, hazard-free,
  // non-flush cycle while out of reset; a stall advances a bubble instead.
  logic adv;
  logic take;
  assign adv      = !out_valid || out_ready;
  assign in_ready = rstn && adv && !hazard && !flush;
  assign take     = in_valid && !hazard;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid    <= 1'b0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      out_imm      <= '0;
      out_aux      <= '0;
      out_pc       <= '0;
      out_rs1      <= '0;
      out_rs2      <= '0;
      out_rd       <= '0;
      out_opcode   <= '0;
      out_funct3   <= '0;
      out_funct7   <= '0;
      out_illegal  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (adv) begin
      out_valid <= take;
      if (take) begin
        out_rs1_data <= rs1_val;
        out_rs2_data <= rs2_val;
        out_imm      <= imm;
        out_aux      <= aux;
        out_pc       <= in_pc;
        out_rs1      <= rs1;
        out_rs2      <= rs2;
        out_rd       <= rd;
        out_opcode   <= opcode;
        out_funct3   <= funct3;
        out_funct7   <= funct7;
        out_illegal  <= illegal;
      end
    end
  end

endmodule
